// File: rtl/br_pkg.sv
// Shared constants for branch resolution: condition codes,
// FSM encoding and flag bit positions within {z,o,c,n}.
package br_pkg;

  localparam logic [2:0] BR_BEQ    = 3'b000;
  localparam logic [2:0] BR_BNE    = 3'b001;
  localparam logic [2:0] BR_BLT    = 3'b010;
  localparam logic [2:0] BR_BGE    = 3'b011;
  localparam logic [2:0] BR_BLTU   = 3'b100;
  localparam logic [2:0] BR_BGEU   = 3'b101;
  localparam logic [2:0] BR_ALWAYS = 3'b110;
  localparam logic [2:0] BR_NEVER  = 3'b111;

  localparam int FLG_Z = 3;
  localparam int FLG_O = 2;
  localparam int FLG_C = 1;
  localparam int FLG_N = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_FLUSH   = 2'd2
  } brState_t;

endpackage

// File: rtl/branch_resolve_if.sv
// Branch request channel from the EX stage into the resolver.
// Valid/ready: the producer holds the branch until br_ready.
interface branch_resolve_if #(
  parameter int PC_W  = 32,
  parameter int IMM_W = 16
);
  logic             br_valid;
  logic [2:0]       br_op;
  logic [PC_W-1:0]  br_pc;
  logic [IMM_W-1:0] br_imm;
  logic             br_ready;

  modport master (
    output br_valid, br_op, br_pc, br_imm,
    input  br_ready
  );

  modport slave (
    input  br_valid, br_op, br_pc, br_imm,
    output br_ready
  );
endinterface

// File: rtl/br_cond_eval.sv
// Pure combinational branch condition check against ALU flags.
// Kept standalone so an early-branch unit can reuse it.
module br_cond_eval
  import br_pkg::*;
(
  input  logic [2:0] op,
  input  logic [3:0] flags,
  output logic       take
);

  logic z, o, c, n;

  assign z = flags[FLG_Z];
  assign o = flags[FLG_O];
  assign c = flags[FLG_C];
  assign n = flags[FLG_N];

  // Decode condition code into the taken decision
  always_comb begin
    take = 1'b0;
    unique case (op)
      BR_BEQ:    take = z;
      BR_BNE:    take = ~z;
      BR_BLT:    take = n ^ o;
      BR_BGE:    take = ~(n ^ o);
      BR_BLTU:   take = ~c;
      BR_BGEU:   take = c;
      BR_ALWAYS: take = 1'b1;
      BR_NEVER:  take = 1'b0;
      default:   take = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// EX/MEM branch resolver: latches ALU flags, decides the branch,
// computes its target and squashes younger slots after a taken one.
module branch_resolve
  import br_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int IMM_W       = 16,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flag_we,
  input  logic            zIn,
  input  logic            oIn,
  input  logic            cIn,
  input  logic            nIn,
  input  logic            stall,
  branch_resolve_if.slave brIf,
  output logic            take,
  output logic [PC_W-1:0] target,
  output logic            resolved,
  output logic            flush,
  output logic [3:0]      flags_q
);

  brState_t state, stateNext;

  logic            takeQ;
  logic [2:0]      flushCnt;
  logic [3:0]      flagsIn;
  logic [3:0]      evalFlags;
  logic            condTake;
  logic            accept;
  logic [PC_W-1:0] immExt;
  logic [PC_W-1:0] targetNext;

  assign flagsIn   = {zIn, oIn, cIn, nIn};
  assign evalFlags = flag_we ? flagsIn : flags_q;

  assign brIf.br_ready = (state == ST_IDLE);
  assign accept        = brIf.br_valid & brIf.br_ready;

  assign immExt = {{(PC_W-IMM_W){brIf.br_imm[IMM_W-1]}},
                   brIf.br_imm};
  assign targetNext = brIf.br_pc + PC_W'(4)
                    + (immExt << 2);

  br_cond_eval u_cond (
    .op    (brIf.br_op),
    .flags (evalFlags),
    .take  (condTake)
  );

  assign resolved = (state == ST_RESOLVE);
  assign flush    = (state == ST_FLUSH);
  assign take     = takeQ & (state != ST_IDLE);

  // Flag register, written whenever the ALU publishes flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= '0;
    else if (flag_we) flags_q <= flagsIn;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= stateNext;
  end

  // Next-state decision; stall freezes RESOLVE and FLUSH
  always_comb begin
    stateNext = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) stateNext = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        if (!stall)
          stateNext = takeQ ? ST_FLUSH : ST_IDLE;
      end
      ST_FLUSH: begin
        if (!stall && flushCnt == 3'd1)
          stateNext = ST_IDLE;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  // Capture decision and target at accept; held until next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      takeQ  <= 1'b0;
      target <= '0;
    end else if (accept) begin
      takeQ  <= condTake;
      target <= targetNext;
    end
  end

  // Flush length counter, only advances on non-stalled cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flushCnt <= '0;
    end else if (state == ST_RESOLVE) begin
      if (!stall && takeQ) flushCnt <= 3'(FLUSH_DEPTH);
    end else if (state == ST_FLUSH) begin
      if (!stall) flushCnt <= flushCnt - 3'd1;
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: vector table, directed corner cases,
// and random branches checked against a rule-level model.
module tb_branch_resolve;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flag_we = 1'b0;
  logic        zIn = 1'b0, oIn = 1'b0;
  logic        cIn = 1'b0, nIn = 1'b0;
  logic        stall = 1'b0;
  logic        take, resolved, flush;
  logic [31:0] target;
  logic [3:0]  flags_q;

  int nChecks = 0;
  int nFail   = 0;

  branch_resolve_if #(.PC_W(32), .IMM_W(16)) brIf ();

  branch_resolve #(
    .PC_W(32), .IMM_W(16), .FLUSH_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flag_we  (flag_we),
    .zIn      (zIn),
    .oIn      (oIn),
    .cIn      (cIn),
    .nIn      (nIn),
    .stall    (stall),
    .brIf     (brIf),
    .take     (take),
    .target   (target),
    .resolved (resolved),
    .flush    (flush),
    .flags_q  (flags_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  flags;
    logic [31:0] pc;
    logic [15:0] imm;
    logic        expTake;
    logic [31:0] expTarget;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic modelTake(logic [2:0] op,
                                     logic [3:0] f);
    bit z = f[3], o = f[2], c = f[1], n = f[0];
    bit signedLess = (n != o);
    case (op)
      3'd0: return z;
      3'd1: return !z;
      3'd2: return signedLess;
      3'd3: return !signedLess;
      3'd4: return !c;
      3'd5: return c;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] modelTarget(logic [31:0] pc,
                                              logic [15:0] imm);
    int off;
    off = int'($signed(imm)) * 4;
    return pc + 32'd4 + 32'(off);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setFlags(logic [3:0] f);
    {zIn, oIn, cIn, nIn} = f;
  endtask

  task automatic loadFlags(logic [3:0] f);
    flag_we = 1'b1;
    setFlags(f);
    tick();
    flag_we = 1'b0;
    chk("flags_q load", 32'(flags_q), 32'(f));
  endtask

  task automatic runBranch(string name, logic [2:0] op,
                           logic [3:0] f, bit useWe,
                           logic [31:0] pc, logic [15:0] imm,
                           int stallRes, int stallFlush,
                           logic expTake, logic [31:0] expTgt);
    int fc, sl, guard;
    chk({name, " ready"}, 32'(brIf.br_ready), 32'd1);
    flag_we = useWe;
    if (useWe) setFlags(f);
    brIf.br_valid = 1'b1;
    brIf.br_op    = op;
    brIf.br_pc    = pc;
    brIf.br_imm   = imm;
    stall = 1'b0;
    tick();
    brIf.br_valid = 1'b0;
    flag_we = 1'b0;
    chk({name, " resolved"}, 32'(resolved), 32'd1);
    chk({name, " take"}, 32'(take), 32'(expTake));
    chk({name, " target"}, target, expTgt);
    chk({name, " busy"}, 32'(brIf.br_ready), 32'd0);
    if (useWe) chk({name, " fwd flags_q"}, 32'(flags_q), 32'(f));
    for (int i = 0; i < stallRes; i++) begin
      stall = 1'b1;
      tick();
      chk({name, " stall resolved"}, 32'(resolved), 32'd1);
      chk({name, " stall take"}, 32'(take), 32'(expTake));
      chk({name, " stall target"}, target, expTgt);
    end
    stall = 1'b0;
    tick();
    fc = 0;
    sl = stallFlush;
    guard = 0;
    while (flush && guard < 40) begin
      fc++;
      chk({name, " flush take"}, 32'(take), 32'(expTake));
      chk({name, " flush target"}, target, expTgt);
      chk({name, " flush busy"}, 32'(brIf.br_ready), 32'd0);
      stall = (sl > 0);
      if (sl > 0) sl--;
      tick();
      guard++;
    end
    stall = 1'b0;
    chk({name, " flush len"}, 32'(fc),
        expTake ? 32'(DEPTH + stallFlush) : 32'd0);
    chk({name, " idle ready"}, 32'(brIf.br_ready), 32'd1);
    chk({name, " idle resolved"}, 32'(resolved), 32'd0);
    chk({name, " idle take"}, 32'(take), 32'd0);
    chk({name, " idle target"}, target, expTgt);
  endtask

  initial begin
    brIf.br_valid = 1'b0;
    brIf.br_op    = '0;
    brIf.br_pc    = '0;
    brIf.br_imm   = '0;

    vecs[0] = '{3'd0, 4'b1000, 32'h100, 16'd3, 1'b1, 32'h110};
    vecs[1] = '{3'd0, 4'b0000, 32'h200, 16'd0, 1'b0, 32'h204};
    vecs[2] = '{3'd1, 4'b0000, 32'h1000, 16'hFFFF, 1'b1, 32'h1000};
    vecs[3] = '{3'd6, 4'b0000, 32'h0, 16'hFFFE, 1'b1, 32'hFFFFFFFC};
    vecs[4] = '{3'd7, 4'b1111, 32'h40, 16'd1, 1'b0, 32'h48};
    vecs[5] = '{3'd5, 4'b0010, 32'h80, 16'd2, 1'b1, 32'h8C};
    vecs[6] = '{3'd4, 4'b0010, 32'h80, 16'd2, 1'b0, 32'h8C};
    vecs[7] = '{3'd3, 4'b0101, 32'hFFFFFFF8, 16'd2, 1'b1, 32'h4};
    vecs[8] = '{3'd2, 4'b0001, 32'h10, 16'h8000, 1'b1, 32'hFFFE0014};

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst flush", 32'(flush), 32'd0);
    chk("rst resolved", 32'(resolved), 32'd0);
    chk("rst take", 32'(take), 32'd0);
    chk("rst target", target, 32'd0);
    chk("rst flags_q", 32'(flags_q), 32'd0);
    chk("rst ready", 32'(brIf.br_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i])
      runBranch($sformatf("vec%0d", i), vecs[i].op, vecs[i].flags,
                1'b1, vecs[i].pc, vecs[i].imm, 0, 0,
                vecs[i].expTake, vecs[i].expTarget);

    // signed compare from registered flags
    loadFlags(4'b0100);
    runBranch("blt o", 3'd2, 4'b0100, 1'b0, 32'h20, 16'd1,
              0, 0, 1'b1, 32'h28);
    loadFlags(4'b0101);
    runBranch("blt on", 3'd2, 4'b0101, 1'b0, 32'h20, 16'd1,
              0, 0, 1'b0, 32'h28);

    // stall in RESOLVE and in FLUSH
    runBranch("stall", 3'd6, 4'b0000, 1'b1, 32'h400, 16'd4,
              3, 1, 1'b1, 32'h414);

    // branch offered during flush waits for ready
    brIf.br_valid = 1'b1;
    brIf.br_op = 3'd6;
    brIf.br_pc = 32'h300;
    brIf.br_imm = 16'd1;
    tick();
    chk("hold resolved", 32'(resolved), 32'd1);
    brIf.br_op = 3'd7;
    brIf.br_pc = 32'h500;
    brIf.br_imm = 16'd0;
    tick();
    chk("hold flush1", 32'(flush), 32'd1);
    chk("hold ready1", 32'(brIf.br_ready), 32'd0);
    chk("hold resolved1", 32'(resolved), 32'd0);
    tick();
    chk("hold flush2", 32'(flush), 32'd1);
    chk("hold target2", target, 32'h308);
    tick();
    chk("hold ready3", 32'(brIf.br_ready), 32'd1);
    tick();
    brIf.br_valid = 1'b0;
    chk("hold new resolved", 32'(resolved), 32'd1);
    chk("hold new take", 32'(take), 32'd0);
    chk("hold new target", target, 32'h504);
    tick();
    chk("hold back idle", 32'(brIf.br_ready), 32'd1);

    // random branches
    for (int k = 0; k < 40; k++) begin
      logic [2:0]  op;
      logic [3:0]  f;
      logic [31:0] pc;
      logic [15:0] imm;
      bit          we;
      op  = 3'($urandom_range(0, 7));
      f   = 4'($urandom_range(0, 15));
      pc  = $urandom;
      imm = 16'($urandom);
      we  = 1'($urandom_range(0, 1));
      if (!we) loadFlags(f);
      runBranch($sformatf("rnd%0d", k), op, f, we, pc, imm,
                int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)),
                modelTake(op, f), modelTarget(pc, imm));
    end

    // asynchronous reset in the middle of a flush
    loadFlags(4'b1011);
    brIf.br_valid = 1'b1;
    brIf.br_op = 3'd6;
    brIf.br_pc = 32'h100;
    brIf.br_imm = 16'd0;
    tick();
    brIf.br_valid = 1'b0;
    tick();
    chk("mid flush", 32'(flush), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst flush", 32'(flush), 32'd0);
    chk("arst ready", 32'(brIf.br_ready), 32'd1);
    chk("arst flags_q", 32'(flags_q), 32'd0);
    chk("arst take", 32'(take), 32'd0);
    chk("arst target", target, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post rst ready", 32'(brIf.br_ready), 32'd1);
    chk("post rst flush", 32'(flush), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

endmodule
